// File: rtl/life_scheduler_pkg.sv
// Shared scheduler types and defaults.
// FSM encodings and board geometry.
package life_scheduler_pkg;

  localparam int DEF_LOG_MAX_SPEED  = 4;
  localparam int DEF_LOG_BOARD_SIZE = 4;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t S_IDLE   = 2'd0;
  localparam sched_state_t S_TOGGLE = 2'd1;
  localparam sched_state_t S_STEP   = 2'd2;
  localparam sched_state_t S_SWAP   = 2'd3;

endpackage

// File: rtl/life_scheduler_step_pacer.sv
// Frame-based step pacing.
// Raises step_due once every (2**LOG_MAX_SPEED - speed) frames.
module step_pacer
  import life_scheduler_pkg::*;
#(
  parameter int LOG_MAX_SPEED = DEF_LOG_MAX_SPEED
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     vsync_in,
  input  logic                     clear_in,
  output logic                     step_due_out
);

  localparam int W = LOG_MAX_SPEED + 1;
  localparam logic [W-1:0] FULL = {1'b1, {LOG_MAX_SPEED{1'b0}}};

  logic [W-1:0] frame_cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] period;

  assign period  = FULL - {1'b0, speed_in};
  assign cnt_nxt = frame_cnt + 1'b1;

  // Count frames; >= compare so a lowered period fires at once.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt    <= '0;
      step_due_out <= 1'b0;
    end else begin
      if (clear_in)
        step_due_out <= 1'b0;
      if (vsync_in && speed_in != '0) begin
        if (cnt_nxt >= period) begin
          step_due_out <= 1'b1;
          frame_cnt    <= '0;
        end else begin
          frame_cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/life_scheduler.sv
// Game-of-Life sequencer: pacing, toggle
// arbitration and frame-aligned buffer flips.
module life_scheduler
  import life_scheduler_pkg::*;
#(
  parameter int LOG_MAX_SPEED    = DEF_LOG_MAX_SPEED,
  parameter int LOG_BOARD_SIZE   = DEF_LOG_BOARD_SIZE,
  parameter int LOG_STEP_TIMEOUT = 20
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [LOG_MAX_SPEED-1:0]  speed_in,
  input  logic                      click_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic                      vsync_in,
  input  logic                      step_done_in,
  input  logic                      toggle_ack_in,
  output logic                      step_start_out,
  output logic                      toggle_req_out,
  output logic [LOG_BOARD_SIZE-1:0] toggle_x_out,
  output logic [LOG_BOARD_SIZE-1:0] toggle_y_out,
  output logic                      buf_sel_out,
  output logic [15:0]               gen_count_out,
  output logic                      busy_out,
  output logic                      error_out
);

  localparam logic [LOG_STEP_TIMEOUT-1:0] WD_MAX =
    {LOG_STEP_TIMEOUT{1'b1}};

  sched_state_t                state;
  logic                        click_q;
  logic                        pending;
  logic                        rise;
  logic                        step_due;
  logic                        launch;
  logic [LOG_STEP_TIMEOUT-1:0] wd;
  logic [LOG_STEP_TIMEOUT-1:0] wd_nxt;

  assign rise   = click_in & ~click_q;
  assign wd_nxt = wd + 1'b1;
  assign launch = (state == S_IDLE) && !(pending || rise)
                  && step_due;

  assign toggle_req_out = (state == S_TOGGLE);
  assign busy_out       = (state != S_IDLE);

  step_pacer #(
    .LOG_MAX_SPEED(LOG_MAX_SPEED)
  ) u_pacer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .speed_in    (speed_in),
    .vsync_in    (vsync_in),
    .clear_in    (launch),
    .step_due_out(step_due)
  );

  // Sequencer: toggles beat steps; flips wait for vsync.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      click_q        <= 1'b1;
      pending        <= 1'b0;
      toggle_x_out   <= '0;
      toggle_y_out   <= '0;
      step_start_out <= 1'b0;
      wd             <= '0;
      buf_sel_out    <= 1'b0;
      gen_count_out  <= '0;
      error_out      <= 1'b0;
    end else begin
      click_q        <= click_in;
      step_start_out <= 1'b0;
      if (rise && !pending) begin
        pending      <= 1'b1;
        toggle_x_out <= cursor_x_in;
        toggle_y_out <= cursor_y_in;
      end
      unique case (state)
        S_IDLE: begin
          if (pending || rise) begin
            state <= S_TOGGLE;
          end else if (step_due) begin
            state          <= S_STEP;
            step_start_out <= 1'b1;
            wd             <= '0;
          end
        end
        S_TOGGLE: begin
          if (toggle_ack_in) begin
            pending <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_STEP: begin
          if (step_done_in) begin
            state <= S_SWAP;
          end else if (wd_nxt == WD_MAX) begin
            error_out <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd <= wd_nxt;
          end
        end
        S_SWAP: begin
          if (vsync_in) begin
            buf_sel_out   <= ~buf_sel_out;
            gen_count_out <= gen_count_out + 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_scheduler.sv
// Directed bench for life_scheduler with a
// small engine model (done 5 cycles after start).
module tb_life_scheduler;

  localparam int LMS = 4;
  localparam int LBS = 4;
  localparam int LST = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [LMS-1:0] speed;
  logic           click;
  logic [LBS-1:0] cx, cy;
  logic           vsync;
  logic           step_done;
  logic           ack;
  logic           step_start;
  logic           req;
  logic [LBS-1:0] tx, ty;
  logic           buf_sel;
  logic [15:0]    gen;
  logic           busy;
  logic           err;

  int total  = 0;
  int passed = 0;
  int starts = 0;
  int wide   = 0;
  int flips  = 0;
  int bad_flip = 0;
  logic start_q = 1'b0;
  logic bs_q = 1'b0;
  bit   eng_en = 1'b1;
  int   eng_cnt = 0;

  life_scheduler #(
    .LOG_MAX_SPEED   (LMS),
    .LOG_BOARD_SIZE  (LBS),
    .LOG_STEP_TIMEOUT(LST)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .speed_in      (speed),
    .click_in      (click),
    .cursor_x_in   (cx),
    .cursor_y_in   (cy),
    .vsync_in      (vsync),
    .step_done_in  (step_done),
    .toggle_ack_in (ack),
    .step_start_out(step_start),
    .toggle_req_out(req),
    .toggle_x_out  (tx),
    .toggle_y_out  (ty),
    .buf_sel_out   (buf_sel),
    .gen_count_out (gen),
    .busy_out      (busy),
    .error_out     (err)
  );

  always #5 clk = ~clk;

  // Engine model: done pulse 5 cycles after start
  always @(negedge clk) begin
    step_done = 1'b0;
    if (!eng_en) begin
      eng_cnt = 0;
    end else if (step_start) begin
      eng_cnt = 5;
    end else if (eng_cnt != 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) step_done = 1'b1;
    end
  end

  // Monitor start pulses and buffer flips
  always @(posedge clk) begin
    #1;
    if (step_start) starts++;
    if (step_start && start_q) wide++;
    start_q = step_start;
    if (buf_sel !== bs_q) begin
      flips++;
      if (!vsync) bad_flip++;
    end
    bs_q = buf_sel;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  initial begin
    step_done = 1'b0;
    rst   = 1'b1;
    speed = '0;
    click = 1'b0;
    cx    = '0;
    cy    = '0;
    vsync = 1'b0;
    ack   = 1'b0;
    tick(3);
    chk("rst_start", step_start, 0);
    chk("rst_req", req, 0);
    chk("rst_buf", buf_sel, 0);
    chk("rst_gen", gen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick(2);

    // fastest speed: one step per frame
    speed = 4'd15;
    vsync_pulse();
    tick(1);
    chk("a_first_start", starts, 1);
    chk("a_busy", busy, 1);
    tick(11);
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      tick(11);
    end
    speed = '0;
    vsync_pulse();
    tick(3);
    chk("a_starts", starts, 4);
    chk("a_wide", wide, 0);
    chk("a_flips", flips, 4);
    chk("a_gen", gen, 4);
    chk("a_buf", buf_sel, 0);
    chk("a_idle", busy, 0);

    // paused: no steps
    for (int i = 0; i < 10; i++) begin
      vsync_pulse();
      tick(2);
    end
    chk("b_paused", starts, 4);
    speed = 4'd14;
    vsync_pulse();
    tick(3);
    chk("b_one_vs", starts, 4);
    vsync_pulse();
    tick(3);
    chk("b_two_vs", starts, 5);
    tick(8);
    chk("b_swap_wait", busy, 1);
    speed = '0;
    vsync_pulse();
    tick(2);
    chk("b_gen", gen, 5);
    chk("b_buf", buf_sel, 1);

    // click while idle
    cx = 4'd5;
    cy = 4'd9;
    click = 1'b1;
    tick(1);
    chk("c_req", req, 1);
    chk("c_x", tx, 5);
    chk("c_y", ty, 9);
    speed = 4'd15;
    vsync_pulse();
    speed = '0;
    tick(1);
    chk("c_req_hold", req, 1);
    chk("c_no_step", starts, 5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("c_req_drop", req, 0);
    chk("c_no_step2", starts, 5);
    click = 1'b0;
    tick(10);
    chk("c_step_after", starts, 6);
    vsync_pulse();
    tick(2);
    chk("c_gen", gen, 6);

    // clicks during step and swap
    speed = 4'd15;
    vsync_pulse();
    speed = '0;
    tick(1);
    cx = 4'd3;
    cy = 4'd3;
    click = 1'b1;
    tick(1);
    click = 1'b0;
    chk("d_no_req_step", req, 0);
    tick(8);
    cx = 4'd7;
    cy = 4'd7;
    click = 1'b1;
    tick(1);
    click = 1'b0;
    tick(2);
    chk("d_no_req_swap", req, 0);
    chk("d_swap_busy", busy, 1);
    vsync_pulse();
    tick(1);
    chk("d_req", req, 1);
    chk("d_x", tx, 3);
    chk("d_y", ty, 3);
    chk("d_gen", gen, 7);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("d_req_drop", req, 0);
    tick(3);
    chk("d_dropped", req, 0);
    chk("d_idle", busy, 0);

    // watchdog
    eng_en = 1'b0;
    speed = 4'd15;
    vsync_pulse();
    speed = '0;
    tick(1);
    chk("e_in_step", busy, 1);
    tick(14);
    chk("e_no_err_yet", err, 0);
    chk("e_still_step", busy, 1);
    tick(1);
    chk("e_err", err, 1);
    chk("e_idle", busy, 0);
    chk("e_buf", buf_sel, 1);
    chk("e_gen", gen, 7);
    eng_en = 1'b1;
    speed = 4'd15;
    vsync_pulse();
    speed = '0;
    tick(1);
    chk("e_relaunch", starts, 9);
    tick(10);
    vsync_pulse();
    tick(2);
    chk("e_gen2", gen, 8);
    chk("e_buf2", buf_sel, 0);
    chk("e_err_sticky", err, 1);
    chk("flip_on_vsync", bad_flip, 0);
    chk("start_width", wide, 0);

    // reset mid-swap with click held
    speed = 4'd15;
    vsync_pulse();
    speed = '0;
    tick(10);
    chk("f_swap", busy, 1);
    click = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("f_req", req, 0);
    chk("f_busy", busy, 0);
    chk("f_buf", buf_sel, 0);
    chk("f_gen", gen, 0);
    chk("f_err", err, 0);
    chk("f_start", step_start, 0);
    rst = 1'b0;
    tick(4);
    chk("f_no_toggle", req, 0);
    chk("f_still_idle", busy, 0);
    click = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
